aer_step_scheduler: RTL and testbench

Time-step scheduler for the Izhikevich neuron array and its AER output path. On each step request it pulses the array enable, waits a fixed neuron-update latency, and captures the spike vector. It then serializes every captured spike into address events over a valid/ready handshake, using round-robin priority that persists across steps, and signals step completion. It sits between the global step timer and the downstream synapse/routing logic.

---
 rtl/aer_step_scheduler_if.sv | 12 +
 rtl/aer_step_scheduler.sv | 143 ++++++++++++++
 tb/tb_aer_step_scheduler.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/aer_step_scheduler_if.sv
// Address-event handshake between the step scheduler and the downstream
// synapse/routing logic: one registered address per accepted valid/ready beat.
interface aer_step_scheduler_if #(
  parameter int NEURON_ADR = 8
);
  logic                  AER_VALID;
  logic [NEURON_ADR:0]   AER_ADDR;
  logic                  AER_READY;

  modport master (output AER_VALID, output AER_ADDR, input AER_READY);
  modport slave  (input AER_VALID, input AER_ADDR, output AER_READY);
endinterface

// File: rtl/aer_step_scheduler.sv
// Time-step scheduler: pulses the neuron array, waits its update latency,
// captures the spike vector and drains it as round-robin address events.
module aer_step_scheduler #(
  parameter int NEURON_NUM = 8,
  parameter int NEURON_ADR = 8,
  parameter int NEURON_LAT = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  STEP_REQ,
  input  logic [NEURON_NUM:0]   SPIKES,
  output logic                  EN_NEURON,
  aer_step_scheduler_if.master  aer,
  output logic                  BUSY,
  output logic                  STEP_DONE,
  output logic [NEURON_ADR:0]   SPIKE_CNT,
  output logic                  OVERRUN
);

  localparam int AW = NEURON_ADR + 1;
  localparam int NW = NEURON_NUM + 1;

  typedef logic [AW-1:0] addr_t;
  typedef logic [NW-1:0] vec_t;

  localparam vec_t  ONE  = vec_t'(1);
  localparam addr_t LAST = addr_t'(NEURON_NUM);

  // The spike capture happens on the edge that ends the last WAIT cycle, so
  // the first event is presented NEURON_LAT+1 cycles after the update pulse.
  typedef enum logic [2:0] {
    S_IDLE,
    S_UPDATE,
    S_WAIT,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state;
  vec_t   pending;
  addr_t  rr_ptr;
  addr_t  wait_cnt;
  vec_t   pending_left;
  addr_t  next_ptr;

  // First set bit of vec, searching cyclically from start.
  function automatic addr_t rr_pick(input vec_t vec, input addr_t start);
    addr_t pick;
    logic  found;
    int    idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < NW; k++) begin
      idx = int'(start) + k;
      if (idx >= NW) idx = idx - NW;
      if (!found && ((vec & (ONE << idx)) != '0)) begin
        pick  = addr_t'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign pending_left = pending & ~(ONE << aer.AER_ADDR);
  assign next_ptr     = (aer.AER_ADDR == LAST) ? '0 : aer.AER_ADDR + 1'b1;

  // NOTE: all state below updates with non-blocking assignments so every
  // branch sees the pre-edge values (e.g. pending_left uses the old AER_ADDR).
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state         <= S_IDLE;
      pending       <= '0;
      rr_ptr        <= '0;
      wait_cnt      <= '0;
      EN_NEURON     <= 1'b0;
      aer.AER_VALID <= 1'b0;
      aer.AER_ADDR  <= '0;
      BUSY          <= 1'b0;
      STEP_DONE     <= 1'b0;
      SPIKE_CNT     <= '0;
      OVERRUN       <= 1'b0;
    end else begin
      EN_NEURON <= 1'b0;
      STEP_DONE <= 1'b0;
      if (STEP_REQ && state != S_IDLE) OVERRUN <= 1'b1;

      case (state)
        S_IDLE: begin
          if (STEP_REQ) begin
            state     <= S_UPDATE;
            EN_NEURON <= 1'b1;
            BUSY      <= 1'b1;
            SPIKE_CNT <= '0;
          end
        end

        S_UPDATE: begin
          wait_cnt <= addr_t'(NEURON_LAT - 1);
          state    <= S_WAIT;
        end

        S_WAIT: begin
          if (wait_cnt == '0) begin
            pending <= SPIKES;
            if (SPIKES == '0) begin
              state     <= S_DONE;
              STEP_DONE <= 1'b1;
            end else begin
              state         <= S_DRAIN;
              aer.AER_ADDR  <= rr_pick(SPIKES, rr_ptr);
              aer.AER_VALID <= 1'b1;
            end
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end

        S_DRAIN: begin
          if (aer.AER_VALID && aer.AER_READY) begin
            pending   <= pending_left;
            rr_ptr    <= next_ptr;
            SPIKE_CNT <= SPIKE_CNT + 1'b1;
            if (pending_left != '0) begin
              aer.AER_ADDR <= rr_pick(pending_left, next_ptr);
            end else begin
              aer.AER_VALID <= 1'b0;
              state         <= S_DONE;
              STEP_DONE     <= 1'b1;
            end
          end
        end

        S_DONE: begin
          state <= S_IDLE;
          BUSY  <= 1'b0;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aer_step_scheduler.sv
// Scoreboard bench for aer_step_scheduler: directed steps push expected
// events/completions; a negedge monitor pops and compares them.
module tb_aer_step_scheduler;

  logic       CLK = 1'b0;
  logic       RST;
  logic       STEP_REQ;
  logic [8:0] SPIKES;
  logic       EN_NEURON;
  logic       BUSY;
  logic       STEP_DONE;
  logic [8:0] SPIKE_CNT;
  logic       OVERRUN;

  aer_step_scheduler_if #(.NEURON_ADR(8)) aer ();

  aer_step_scheduler #(
    .NEURON_NUM(8),
    .NEURON_ADR(8),
    .NEURON_LAT(2)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .STEP_REQ  (STEP_REQ),
    .SPIKES    (SPIKES),
    .EN_NEURON (EN_NEURON),
    .aer       (aer),
    .BUSY      (BUSY),
    .STEP_DONE (STEP_DONE),
    .SPIKE_CNT (SPIKE_CNT),
    .OVERRUN   (OVERRUN)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int addr;
    int rel;
  } ev_t;

  typedef struct {
    int cnt;
    int rel;
  } done_t;

  ev_t   ev_q[$];
  done_t done_q[$];
  int    en_q[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int t0 = 0;
  int valid_cycles = 0;
  int done_seen = 0;
  logic prev_stall = 1'b0;
  int   prev_addr = 0;

  always @(posedge CLK) cyc++;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name, input int act);
    checks++;
    errors++;
    $display("FAIL %s: got %0d with nothing expected (t=%0t)", name, act, $time);
  endtask

  // Monitor: compares DUT outputs against the scoreboard queues.
  always @(negedge CLK) begin
    if (!RST) begin
      if (EN_NEURON) begin
        if (en_q.size() == 0) fail("unexpected_en_neuron", cyc - t0);
        else check("en_neuron_cycle", cyc - t0, en_q.pop_front());
      end
      if (aer.AER_VALID) begin
        valid_cycles++;
        if (prev_stall) check("addr_hold_stall", int'(aer.AER_ADDR), prev_addr);
      end
      if (aer.AER_VALID && aer.AER_READY) begin
        if (ev_q.size() == 0) fail("unexpected_event", int'(aer.AER_ADDR));
        else begin
          ev_t e;
          e = ev_q.pop_front();
          check("event_addr", int'(aer.AER_ADDR), e.addr);
          check("event_cycle", cyc - t0, e.rel);
        end
      end
      if (STEP_DONE) begin
        done_seen++;
        if (done_q.size() == 0) fail("unexpected_step_done", cyc - t0);
        else begin
          done_t d;
          d = done_q.pop_front();
          check("spike_cnt_at_done", int'(SPIKE_CNT), d.cnt);
          check("step_done_cycle", cyc - t0, d.rel);
        end
      end
      prev_stall = aer.AER_VALID && !aer.AER_READY;
      prev_addr  = int'(aer.AER_ADDR);
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic exp_ev(input int addr, input int rel);
    ev_t e;
    e.addr = addr;
    e.rel  = rel;
    ev_q.push_back(e);
  endtask

  task automatic exp_done(input int cnt, input int rel);
    done_t d;
    d.cnt = cnt;
    d.rel = rel;
    done_q.push_back(d);
  endtask

  // Runs one step starting now (cycle 0). READY is low for stall_len cycles
  // from stall_k; STEP_REQ is re-pulsed at req_k; RST asserted at rst_k.
  task automatic do_step(input logic [8:0] spikes, input int exp_valid,
                         input int stall_k, input int stall_len,
                         input int req_k, input int rst_k);
    int done_before;
    int k;
    bit finished;
    done_before  = done_seen;
    valid_cycles = 0;
    en_q.push_back(1);
    t0       = cyc;
    SPIKES   = spikes;
    STEP_REQ = 1'b1;
    k        = 0;
    finished = 1'b0;
    while (!finished) begin
      @(posedge CLK);
      #1;
      k++;
      STEP_REQ      = (k == req_k);
      aer.AER_READY = !(k >= stall_k && k < stall_k + stall_len);
      if (k == rst_k) begin
        RST = 1'b1;
        #1;
        check("rst_aer_valid", int'(aer.AER_VALID), 0);
        check("rst_busy", int'(BUSY), 0);
        check("rst_spike_cnt", int'(SPIKE_CNT), 0);
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;
        @(posedge CLK);
        #1;
        check("no_done_after_rst", done_seen - done_before, 0);
        finished = 1'b1;
      end else if (done_seen != done_before) begin
        check("busy_after_done", int'(BUSY), 0);
        finished = 1'b1;
      end else if (k >= 60) begin
        fail("step_timeout", k);
        finished = 1'b1;
      end
    end
    aer.AER_READY = 1'b1;
    check("valid_cycles", valid_cycles, exp_valid);
    check("events_left", ev_q.size(), 0);
    check("dones_left", done_q.size(), 0);
    check("en_left", en_q.size(), 0);
  endtask

  initial begin
    RST           = 1'b1;
    STEP_REQ      = 1'b0;
    SPIKES        = '0;
    aer.AER_READY = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    check("reset_en_neuron", int'(EN_NEURON), 0);
    check("reset_aer_valid", int'(aer.AER_VALID), 0);
    check("reset_aer_addr", int'(aer.AER_ADDR), 0);
    check("reset_busy", int'(BUSY), 0);
    check("reset_step_done", int'(STEP_DONE), 0);
    check("reset_spike_cnt", int'(SPIKE_CNT), 0);
    check("reset_overrun", int'(OVERRUN), 0);
    RST = 1'b0;
    @(posedge CLK);
    #1;

    // No spikes: done two cycles after the wait.
    exp_done(0, 4);
    do_step(9'h000, 0, 0, 0, -1, -1);

    // 0x005 from pointer 0: 0, 2; pointer ends at 3.
    exp_ev(0, 4); exp_ev(2, 5); exp_done(2, 6);
    do_step(9'h005, 2, 0, 0, -1, -1);

    // 0x00D from pointer 3: 3, 0, 2.
    exp_ev(3, 4); exp_ev(0, 5); exp_ev(2, 6); exp_done(3, 7);
    do_step(9'h00D, 3, 0, 0, -1, -1);

    // 0x100 with READY low in cycles 4..6: address 8 held four cycles.
    exp_ev(8, 7); exp_done(1, 8);
    do_step(9'h100, 4, 4, 3, -1, -1);

    // Pointer wrapped to 0 after address 8: 0, 1.
    exp_ev(0, 4); exp_ev(1, 5); exp_done(2, 6);
    do_step(9'h003, 2, 0, 0, -1, -1);
    check("overrun_clear_before", int'(OVERRUN), 0);

    // 0x0F0 from pointer 2, STEP_REQ re-pulsed mid-drain.
    exp_ev(4, 4); exp_ev(5, 5); exp_ev(6, 6); exp_ev(7, 7); exp_done(4, 8);
    do_step(9'h0F0, 4, 0, 0, 5, -1);
    check("overrun_sticky", int'(OVERRUN), 1);
    @(posedge CLK);
    #1;
    check("overrun_sticky_later", int'(OVERRUN), 1);

    // 0x1FF from pointer 8, reset in cycle 6 after 8 and 0 were accepted.
    exp_ev(8, 4); exp_ev(0, 5);
    do_step(9'h1FF, 2, 0, 0, -1, 6);
    check("overrun_cleared_by_rst", int'(OVERRUN), 0);

    // Pointer back at 0 after reset: 0 before 8.
    exp_ev(0, 4); exp_ev(8, 5); exp_done(2, 6);
    do_step(9'h101, 2, 0, 0, -1, -1);

    repeat (2) @(posedge CLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
